phrase_editor: RTL and testbench
================================

PHRASE_EDITOR -- requirements
Module: phrase_editor

Interface
REQ-001 The block SHALL use one clock, clk; reset is asynchronous and active-high, named reset_active_high.
REQ-002 The block SHALL expose parameter LINES, default 16, which sets the number of phrase lines; the address width is log2(LINES).
REQ-003 The block SHALL expose parameter MAX_NOTE, default 8'h6B, which sets the highest legal note code (B_8).
REQ-004 clk  input  1  100 MHz system clock.
REQ-005 reset_active_high  input  1  asynchronous reset, active-high.
REQ-006 btn_up, btn_down, btn_left, btn_right, btn_clear  input  1 each  debounced single-cycle button pulses.
REQ-007 edit_hold  input  1  high = value-edit mode; low = navigation mode.
REQ-008 rd_line  input  4  playback read address.
REQ-009 rd_entry  output  16  registered phrase entry {note[15:8], volume[7:2], instrument[1:0]} at rd_line.
REQ-010 cursor_line  output  4  line under the edit cursor.
REQ-011 cursor_field  output  2  selected field: 0 = note, 1 = volume, 2 = instrument.
REQ-012 cursor_entry  output  16  registered entry at cursor_line, for display.
REQ-013 busy  output  1  high while an edit transaction is in flight.
REQ-014 write_strobe  output  1  single-cycle pulse in the cycle the phrase memory is written.

Function
REQ-015 The block SHALL hold LINES x 16-bit phrase storage; every entry resets to 16'h0000.
REQ-016 rd_entry SHALL equal mem[rd_line] sampled at the previous clock edge (latency 1); when a write to the same line occurs in that edge, rd_entry SHALL return the old data.
REQ-017 cursor_entry SHALL equal mem[cursor_line] from the previous edge, with the same old-data rule.
REQ-018 When several button pulses coincide, only one SHALL be accepted, by priority clear > up > down > left > right; the others are dropped.
REQ-019 Button pulses that arrive while busy=1 SHALL be dropped without side effects.
REQ-020 Navigation (edit_hold=0): up SHALL decrement cursor_line and down SHALL increment it, both wrapping modulo LINES; left and right SHALL be ignored; the update takes effect on the next edge and does not assert busy.
REQ-021 With edit_hold=1, left/right SHALL decrement/increment cursor_field over the values 0..2, wrapping (0 left -> 2, 2 right -> 0), with no memory access.
REQ-022 With edit_hold=1, an accepted up, down, or clear SHALL start a transaction through the FSM IDLE -> FETCH -> APPLY -> COMMIT -> IDLE, one cycle per state.
REQ-023 FETCH SHALL latch mem[cursor_line] and the operation into working registers; cursor_line and cursor_field SHALL be frozen until IDLE is re-entered.
REQ-024 APPLY, note field: up SHALL add 1, saturating at MAX_NOTE; down SHALL subtract 1, saturating at 0; a stored note above MAX_NOTE SHALL be clamped to MAX_NOTE on any edit.
REQ-025 APPLY, volume field: up/down SHALL add/subtract 1, saturating within 0..63.
REQ-026 APPLY, instrument field: up/down SHALL add/subtract 1, wrapping modulo 4.
REQ-027 APPLY, clear SHALL produce 16'h0000 regardless of cursor_field.
REQ-028 In APPLY, fields not being edited SHALL pass through unchanged.
REQ-029 COMMIT SHALL write the result to the latched line and pulse write_strobe for exactly one cycle.
REQ-030 busy SHALL be high in FETCH, APPLY and COMMIT; a button accepted at edge N SHALL write at edge N+3, with the new data visible on rd_entry/cursor_entry after edge N+4.
REQ-031 A write SHALL occur even when the saturated result equals the old value.
REQ-032 A change of edit_hold during a transaction SHALL NOT affect that transaction.

Reset
REQ-033 On reset_active_high=1, the block SHALL immediately force FSM=IDLE, cursor_line=0, cursor_field=0, busy=0, write_strobe=0, rd_entry=0, cursor_entry=0 and all entries to 0.
REQ-034 A reset asserted mid-transaction SHALL abort it with no memory write.
REQ-035 Normal operation SHALL begin at the first clk edge after reset deasserts.

Verification
REQ-036 Reset, set edit_hold=1 and field=note, pulse up 3 times, waiting for busy=0 each time -> mem[0]=16'h0300; write_strobe pulses 3 times; each pulse arrives 3 edges after its button.
REQ-037 Navigation with edit_hold=0: pulse up once at line 0 -> cursor_line=15; pulse down -> cursor_line=0.
REQ-038 Volume field at 63, pulse up -> volume stays 63 and write_strobe still pulses; instrument 3, pulse up -> instrument=0.
REQ-039 Pulse up and btn_clear in the same cycle on an entry of 16'h45FE -> entry becomes 16'h0000; a btn_down pulse issued 1 cycle later while busy is dropped.
REQ-040 rd_line equal to cursor_line during the COMMIT edge -> rd_entry shows old data that cycle and new data one cycle later.
REQ-041 Assert reset in the APPLY state -> no write_strobe, mem unchanged (all zero), all outputs at reset values.

Source files
------------

// File: rtl/phrase_editor.sv
// Phrase editor: cursor navigation plus a four-state read-modify-write
// transaction that edits one field of a phrase entry in LINES x 16-bit storage.
module phrase_editor #(
   parameter int unsigned LINES    = 16,
   parameter logic [7:0]  MAX_NOTE = 8'h6B
) (
   input  logic                       clk,
   input  logic                       reset_active_high,
   input  logic                       btn_up,
   input  logic                       btn_down,
   input  logic                       btn_left,
   input  logic                       btn_right,
   input  logic                       btn_clear,
   input  logic                       edit_hold,
   input  logic [$clog2(LINES)-1:0]   rd_line,
   output logic [15:0]                rd_entry,
   output logic [$clog2(LINES)-1:0]   cursor_line,
   output logic [1:0]                 cursor_field,
   output logic [15:0]                cursor_entry,
   output logic                       busy,
   output logic                       write_strobe
);

   localparam int unsigned AW = $clog2(LINES);

   localparam logic [1:0] F_NOTE = 2'd0;
   localparam logic [1:0] F_VOL  = 2'd1;
   localparam logic [1:0] F_INST = 2'd2;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_APPLY, S_COMMIT} state_t;
   typedef enum logic [1:0] {OP_UP, OP_DOWN, OP_CLEAR} op_t;

   state_t        state;
   op_t           op_q;
   logic [15:0]   work;
   logic [AW-1:0] wline;
   logic [15:0]   mem [LINES];

   // Field edit: note saturates at MAX_NOTE (out-of-range notes clamp first),
   // volume saturates at 0..63, instrument wraps modulo 4.
   function automatic logic [15:0] apply_edit(input logic [15:0] e,
                                              input op_t op,
                                              input logic [1:0] fld);
      logic [7:0] n;
      logic [5:0] v;
      logic [1:0] i;
      n = e[15:8];
      v = e[7:2];
      i = e[1:0];
      case (fld)
         F_NOTE: begin
            if (n > MAX_NOTE) n = MAX_NOTE;
            if (op == OP_UP) begin
               if (n < MAX_NOTE) n = n + 8'd1;
            end else if (n != 8'd0) begin
               n = n - 8'd1;
            end
         end
         F_VOL: begin
            if (op == OP_UP) begin
               if (v != 6'd63) v = v + 6'd1;
            end else if (v != 6'd0) begin
               v = v - 6'd1;
            end
         end
         F_INST: i = (op == OP_UP) ? i + 2'd1 : i - 2'd1;
         default: ;
      endcase
      if (op == OP_CLEAR) apply_edit = 16'h0000;
      else                apply_edit = {n, v, i};
   endfunction

   always_ff @(posedge clk or posedge reset_active_high) begin
      if (reset_active_high) begin
         state        <= S_IDLE;
         op_q         <= OP_UP;
         work         <= 16'h0000;
         wline        <= '0;
         cursor_line  <= '0;
         cursor_field <= F_NOTE;
         busy         <= 1'b0;
         write_strobe <= 1'b0;
         rd_entry     <= 16'h0000;
         cursor_entry <= 16'h0000;
         mem          <= '{default: 16'h0000};
      end else begin
         rd_entry     <= mem[rd_line];
         cursor_entry <= mem[cursor_line];
         write_strobe <= 1'b0;
         case (state)
            S_IDLE: begin
               // Single accepted button per cycle: clear > up > down > left > right
               if (btn_clear) begin
                  if (edit_hold) begin
                     op_q  <= OP_CLEAR;
                     state <= S_FETCH;
                     busy  <= 1'b1;
                  end
               end else if (btn_up) begin
                  if (edit_hold) begin
                     op_q  <= OP_UP;
                     state <= S_FETCH;
                     busy  <= 1'b1;
                  end else if (cursor_line == '0) begin
                     cursor_line <= AW'(LINES - 1);
                  end else begin
                     cursor_line <= cursor_line - AW'(1);
                  end
               end else if (btn_down) begin
                  if (edit_hold) begin
                     op_q  <= OP_DOWN;
                     state <= S_FETCH;
                     busy  <= 1'b1;
                  end else if (cursor_line == AW'(LINES - 1)) begin
                     cursor_line <= '0;
                  end else begin
                     cursor_line <= cursor_line + AW'(1);
                  end
               end else if (btn_left) begin
                  if (edit_hold)
                     cursor_field <= (cursor_field == F_NOTE) ? F_INST : cursor_field - 2'd1;
               end else if (btn_right) begin
                  if (edit_hold)
                     cursor_field <= (cursor_field == F_INST) ? F_NOTE : cursor_field + 2'd1;
               end
            end
            S_FETCH: begin
               work  <= mem[cursor_line];
               wline <= cursor_line;
               state <= S_APPLY;
            end
            S_APPLY: begin
               work         <= apply_edit(work, op_q, cursor_field);
               write_strobe <= 1'b1;
               state        <= S_COMMIT;
            end
            S_COMMIT: begin
               mem[wline] <= work;
               busy       <= 1'b0;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_phrase_editor.sv
// Scoreboarded bench for phrase_editor: stimulus queues expected writes,
// a negedge monitor checks strobe timing, line, width and written data.
module tb_phrase_editor;

   logic        clk = 1'b0;
   logic        reset_active_high;
   logic        btn_up, btn_down, btn_left, btn_right, btn_clear;
   logic        edit_hold;
   logic [3:0]  rd_line;
   logic [15:0] rd_entry;
   logic [3:0]  cursor_line;
   logic [1:0]  cursor_field;
   logic [15:0] cursor_entry;
   logic        busy;
   logic        write_strobe;

   always #5 clk = ~clk;

   phrase_editor dut (
      .clk               (clk),
      .reset_active_high (reset_active_high),
      .btn_up            (btn_up),
      .btn_down          (btn_down),
      .btn_left          (btn_left),
      .btn_right         (btn_right),
      .btn_clear         (btn_clear),
      .edit_hold         (edit_hold),
      .rd_line           (rd_line),
      .rd_entry          (rd_entry),
      .cursor_line       (cursor_line),
      .cursor_field      (cursor_field),
      .cursor_entry      (cursor_entry),
      .busy              (busy),
      .write_strobe      (write_strobe)
   );

   localparam logic [4:0] B_CLR = 5'b10000;
   localparam logic [4:0] B_UP  = 5'b01000;
   localparam logic [4:0] B_DN  = 5'b00100;
   localparam logic [4:0] B_LF  = 5'b00010;
   localparam logic [4:0] B_RT  = 5'b00001;

   typedef struct {
      logic [3:0]  line;
      logic [15:0] data;
      int          cyc;
   } exp_t;

   exp_t       sb[$];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   logic [3:0] tline = 4'd0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive a one-cycle button pulse starting at a negedge.
   task automatic press(input logic [4:0] b);
      {btn_clear, btn_up, btn_down, btn_left, btn_right} = b;
      @(negedge clk);
      {btn_clear, btn_up, btn_down, btn_left, btn_right} = 5'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: busy still %b after %0d cycles", busy, n);
      end
   endtask

   // Pulse a button in edit mode and queue the write it should cause.
   task automatic press_w(input logic [4:0] b, input logic [15:0] data);
      sb.push_back('{tline, data, cyc + 3});
      press(b);
      wait_idle();
   endtask

   task automatic edit(input logic [4:0] b);
      edit_hold = 1'b1;
      press(b);
      wait_idle();
   endtask

   task automatic nav(input logic [4:0] b);
      edit_hold = 1'b0;
      press(b);
   endtask

   // Monitor: every write_strobe must match the oldest queued write.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (write_strobe) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: strobe at cycle %0d line %0d", cyc, cursor_line);
            end else begin
               e = sb.pop_front();
               chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
               chk("write_line", 32'(cursor_line), 32'(e.line));
               @(negedge clk);
               chk("strobe_width", 32'(write_strobe), 32'd0);
               @(negedge clk);
               chk("write_data", 32'(cursor_entry), 32'(e.data));
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset_active_high = 1'b1;
      {btn_clear, btn_up, btn_down, btn_left, btn_right} = 5'b0;
      edit_hold = 1'b0;
      rd_line   = 4'd0;
      repeat (2) @(negedge clk);
      chk("rst_cursor_line", 32'(cursor_line), 32'd0);
      chk("rst_cursor_field", 32'(cursor_field), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rd_entry", 32'(rd_entry), 32'd0);
      reset_active_high = 1'b0;
      @(negedge clk);

      // Note up x3 on line 0; edit_hold toggled mid-transaction on the last.
      edit_hold = 1'b1;
      press_w(B_UP, 16'h0100);
      chk("busy_done", 32'(busy), 32'd0);
      press_w(B_UP, 16'h0200);
      sb.push_back('{tline, 16'h0300, cyc + 3});
      press(B_UP);
      chk("busy_in_fetch", 32'(busy), 32'd1);
      edit_hold = 1'b0;
      @(negedge clk);
      edit_hold = 1'b1;
      wait_idle();
      @(negedge clk);
      chk("rd_line0", 32'(rd_entry), 32'h0300);

      // Navigation wraps; left/right ignored.
      nav(B_UP);
      chk("nav_up_wrap", 32'(cursor_line), 32'd15);
      chk("nav_no_busy", 32'(busy), 32'd0);
      nav(B_DN);
      chk("nav_down_wrap", 32'(cursor_line), 32'd0);
      nav(B_RT);
      chk("nav_right_ignored", 32'(cursor_field), 32'd0);

      // Volume up to 63 then saturate; instrument wraps both ways.
      edit(B_RT);
      chk("field_vol", 32'(cursor_field), 32'd1);
      for (int v = 1; v <= 63; v++) press_w(B_UP, {8'h03, 6'(v), 2'b00});
      press_w(B_UP, 16'h03FC);
      edit(B_RT);
      chk("field_inst", 32'(cursor_field), 32'd2);
      press_w(B_UP, 16'h03FD);
      press_w(B_UP, 16'h03FE);
      press_w(B_UP, 16'h03FF);
      press_w(B_UP, 16'h03FC);
      press_w(B_DN, 16'h03FF);
      edit(B_RT);
      chk("field_wrap_right", 32'(cursor_field), 32'd0);
      edit(B_LF);
      chk("field_wrap_left", 32'(cursor_field), 32'd2);

      // Build 16'h45FE on line 1.
      nav(B_DN);
      tline = 4'd1;
      chk("nav_line1", 32'(cursor_line), 32'd1);
      edit(B_LF);
      edit(B_LF);
      chk("field_note", 32'(cursor_field), 32'd0);
      for (int n = 1; n <= 69; n++) press_w(B_UP, {8'(n), 8'h00});
      edit(B_RT);
      for (int v = 1; v <= 63; v++) press_w(B_UP, {8'h45, 6'(v), 2'b00});
      edit(B_RT);
      press_w(B_UP, 16'h45FD);
      press_w(B_UP, 16'h45FE);
      rd_line = 4'd1;
      @(negedge clk);
      chk("rd_line1", 32'(rd_entry), 32'h45FE);

      // Clear beats up; a down one cycle later is dropped.
      sb.push_back('{tline, 16'h0000, cyc + 3});
      press(B_CLR | B_UP);
      press(B_DN);
      wait_idle();
      chk("drop_line", 32'(cursor_line), 32'd1);
      chk("drop_field", 32'(cursor_field), 32'd2);

      // Read of the line being committed returns old data, then new.
      sb.push_back('{tline, 16'h0001, cyc + 3});
      press(B_UP);
      repeat (2) @(negedge clk);
      chk("commit_strobe", 32'(write_strobe), 32'd1);
      chk("rd_before_commit", 32'(rd_entry), 32'h0000);
      @(negedge clk);
      chk("rd_at_commit_old", 32'(rd_entry), 32'h0000);
      @(negedge clk);
      chk("rd_after_commit_new", 32'(rd_entry), 32'h0001);

      // Note saturation at MAX_NOTE on line 2.
      nav(B_DN);
      tline = 4'd2;
      edit(B_LF);
      edit(B_LF);
      for (int n = 1; n <= 108; n++)
         press_w(B_UP, {(n > 107) ? 8'h6B : 8'(n), 8'h00});

      // Down at note 0 still writes.
      nav(B_DN);
      tline = 4'd3;
      edit_hold = 1'b1;
      press_w(B_DN, 16'h0000);

      // Reset during APPLY aborts the write and clears everything.
      press(B_UP);
      @(negedge clk);
      reset_active_high = 1'b1;
      #1;
      chk("abort_cursor_line", 32'(cursor_line), 32'd0);
      chk("abort_cursor_field", 32'(cursor_field), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_strobe", 32'(write_strobe), 32'd0);
      chk("abort_rd_entry", 32'(rd_entry), 32'd0);
      chk("abort_cursor_entry", 32'(cursor_entry), 32'd0);
      repeat (2) @(negedge clk);
      reset_active_high = 1'b0;
      for (int i = 0; i < 16; i++) begin
         rd_line = 4'(i);
         @(negedge clk);
         chk($sformatf("mem_clear_%0d", i), 32'(rd_entry), 32'd0);
      end

      repeat (10) @(negedge clk);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
